// File: rtl/nb_bb_updown_counter.sv
// N-digit, base-B up/down counter with parallel load, optional saturation and a
// combinational carry/borrow out for cascading further instances through eu.
module nb_bb_updown_counter #(
   parameter int N   = 4,
   parameter int B   = 10,
   parameter int SAT = 0,
   localparam int W  = (B <= 2) ? 1 : $clog2(B)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           ei,
   input  logic           up,
   input  logic           load,
   input  logic [N*W-1:0] d,
   output logic [N*W-1:0] q,
   output logic           eu
);

   localparam logic [W-1:0] DIG_MAX  = W'(B - 1);
   localparam logic [W-1:0] DIG_ZERO = {W{1'b0}};
   localparam logic [W:0]   B_EXT    = (W + 1)'(B);

   logic [N*W-1:0] q_r;
   logic [N*W-1:0] q_next_s;
   logic [N-1:0]   term_s;
   logic [N-1:0]   en_s;
   logic           eu_s;

   function automatic logic is_term(input logic [W-1:0] v, input logic dir);
      return dir ? (v == DIG_MAX) : (v == DIG_ZERO);
   endfunction

   function automatic logic [W-1:0] digit_step(input logic [W-1:0] v, input logic dir);
      logic [W-1:0] r;
      if (dir) begin
         r = (v == DIG_MAX) ? DIG_ZERO : v + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r = (v == DIG_ZERO) ? DIG_MAX : v - {{(W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // Out-of-range load digits collapse to zero so no digit can ever reach B.
   function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
      return ({1'b0, v} >= B_EXT) ? DIG_ZERO : v;
   endfunction

   // Per-digit terminal detection and the ripple enable chain.
   always_comb begin
      term_s = {N{1'b0}};
      en_s   = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         term_s[i] = is_term(q_r[i*W +: W], up);
      end
      en_s[0] = ei;
      for (int i = 1; i < N; i++) begin
         en_s[i] = en_s[i-1] & term_s[i-1];
      end
      eu_s = en_s[N-1] & term_s[N-1] & ~load;
   end

   // Next-state selection: load, saturating hold, or per-digit step.
   always_comb begin
      q_next_s = q_r;
      if (load) begin
         for (int i = 0; i < N; i++) begin
            q_next_s[i*W +: W] = sanitize(d[i*W +: W]);
         end
      end else if ((SAT != 0) && eu_s) begin
         q_next_s = q_r;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (en_s[i]) begin
               q_next_s[i*W +: W] = digit_step(q_r[i*W +: W], up);
            end else begin
               q_next_s[i*W +: W] = q_r[i*W +: W];
            end
         end
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_r <= {(N*W){1'b0}};
      end else begin
         q_r <= q_next_s;
      end
   end

   assign q  = q_r;
   assign eu = eu_s;

endmodule

// File: tb/tb_nb_bb_updown_counter.sv
// Directed bench for nb_bb_updown_counter: decimal wrap/borrow/load vectors,
// asynchronous reset, saturating hex and base-2 regression instances.
module tb_nb_bb_updown_counter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // Decimal instance: N=4, B=10, SAT=0
   logic        ei_a = 1'b0, up_a = 1'b1, load_a = 1'b0;
   logic [15:0] d_a = 16'h0000;
   logic [15:0] q_a;
   logic        eu_a;
   // Saturating hex instance: N=2, B=16, SAT=1
   logic        ei_s = 1'b0, up_s = 1'b1, load_s = 1'b0;
   logic [7:0]  d_s = 8'h00;
   logic [7:0]  q_s;
   logic        eu_s;
   // Binary instance: N=4, B=2, SAT=0
   logic        ei_b = 1'b0, up_b = 1'b1, load_b = 1'b0;
   logic [3:0]  d_b = 4'h0;
   logic [3:0]  q_b;
   logic        eu_b;

   nb_bb_updown_counter #(.N(4), .B(10), .SAT(0)) u_dec (
      .clock(clock), .reset(reset), .ei(ei_a), .up(up_a), .load(load_a),
      .d(d_a), .q(q_a), .eu(eu_a));
   nb_bb_updown_counter #(.N(2), .B(16), .SAT(1)) u_sat (
      .clock(clock), .reset(reset), .ei(ei_s), .up(up_s), .load(load_s),
      .d(d_s), .q(q_s), .eu(eu_s));
   nb_bb_updown_counter #(.N(4), .B(2), .SAT(0)) u_bin (
      .clock(clock), .reset(reset), .ei(ei_b), .up(up_b), .load(load_b),
      .d(d_b), .q(q_b), .eu(eu_b));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic        load;
      logic        ei;
      logic        up;
      logic [15:0] d;
      logic        exp_eu;
      logic [15:0] exp_q;
   } vec_t;

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 16'h1000};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0999};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h9999};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h3C71, 1'b0, 16'h3071};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h3072};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h3072};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h3071};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h0019, 1'b0, 16'h0019};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0020};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 16'h0F00, 1'b0, 16'h0000};

      // Reset state with reset held across an edge
      #1;
      chk("reset_q", 32'(q_a), 32'h0);
      chk("reset_eu", 32'(eu_a), 32'h0);
      tick();
      chk("reset_hold_q", 32'(q_a), 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Count a little, then reset asynchronously mid-cycle
      ei_a = 1'b1; up_a = 1'b1;
      repeat (5) tick();
      chk("pre_async_q", 32'(q_a), 32'h0005);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_q", 32'(q_a), 32'h0);
      tick();
      chk("async_reset_held_q", 32'(q_a), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("after_reset_eu", 32'(eu_a), 32'h0);
      repeat (12) tick();
      chk("count12_q", 32'(q_a), 32'h0012);

      // Decimal table
      for (int i = 0; i < 13; i++) begin
         load_a = tbl[i].load; ei_a = tbl[i].ei; up_a = tbl[i].up; d_a = tbl[i].d;
         #1;
         chk($sformatf("vec%0d_eu", i), 32'(eu_a), 32'(tbl[i].exp_eu));
         tick();
         chk($sformatf("vec%0d_q", i), 32'(q_a), 32'(tbl[i].exp_q));
      end
      load_a = 1'b0; ei_a = 1'b0;

      // Saturation on the hex instance
      load_s = 1'b1; d_s = 8'hFF;
      tick();
      chk("sat_load_q", 32'(q_s), 32'hFF);
      load_s = 1'b0; ei_s = 1'b1; up_s = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("sat%0d_eu", k), 32'(eu_s), 32'h1);
         tick();
         chk($sformatf("sat%0d_q", k), 32'(q_s), 32'hFF);
      end
      up_s = 1'b0;
      #1;
      chk("sat_release_eu", 32'(eu_s), 32'h0);
      tick();
      chk("sat_release_q", 32'(q_s), 32'hFE);
      up_s = 1'b1;
      tick();
      chk("sat_up_again_q", 32'(q_s), 32'hFF);
      ei_s = 1'b0;

      // Base-2 full cycle
      ei_b = 1'b1; up_b = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk($sformatf("bin%0d_q", k), 32'(q_b), 32'(k));
         chk($sformatf("bin%0d_eu", k), 32'(eu_b), (k == 15) ? 32'h1 : 32'h0);
         tick();
      end
      chk("bin_wrap_q", 32'(q_b), 32'h0);
      ei_b = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
